// File: rtl/alu_resp.sv
// alu_resp: 256-bit multi-cycle ALU with a valid/ready request and response handshake.
//
// An accepted request is captured in IDLE. The datapath then works on one
// SLICE_W-bit slice per BUSY cycle, least significant slice first, with a
// registered carry between slices. The result is presented in DONE and held
// until the consumer takes it.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   req_valid  in   1    request present
//   req_ready  out  1    block can accept a request (IDLE only)
//   op0_value  in   256  first operand, unsigned
//   op1_value  in   256  second operand, unsigned
//   mode       in   2    0 add, 1 sub, 2 AND, 3 XOR
//   rsp_valid  out  1    result present (DONE only)
//   rsp_ready  in   1    consumer accepts result
//   alu_out    out  256  registered result
//   carry_out  out  1    registered carry out of bit 255 for add/sub, else 0
module alu_resp #(
  parameter int SLICE_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [255:0] op0_value,
  input  logic [255:0] op1_value,
  input  logic [1:0]   mode,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [255:0] alu_out,
  output logic         carry_out
);

  localparam int NSLICE = 256 / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_AND = 2'd2;
  localparam logic [1:0] MODE_XOR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [255:0]       op0_q, op0_d;
  logic [255:0]       op1_q, op1_d;
  logic [1:0]         mode_q, mode_d;
  logic [255:0]       acc_q, acc_d;
  logic [255:0]       alu_out_q, alu_out_d;
  logic               carry_out_q, carry_out_d;

  logic [SLICE_W-1:0] a_s, b_s, b_eff_s, slice_res_s;
  logic [SLICE_W:0]   sum_s;
  logic               slice_cout_s;
  logic [255:0]       acc_ins_s;

  // Slice datapath: operate on the slice selected by the counter.
  always_comb begin
    a_s          = op0_q[cnt_q*SLICE_W +: SLICE_W];
    b_s          = op1_q[cnt_q*SLICE_W +: SLICE_W];
    // Subtraction is op0 + ~op1 + 1; the +1 enters as the initial carry.
    b_eff_s      = (mode_q == MODE_SUB) ? ~b_s : b_s;
    sum_s        = {1'b0, a_s} + {1'b0, b_eff_s} + {{SLICE_W{1'b0}}, carry_q};
    slice_res_s  = {SLICE_W{1'b0}};
    slice_cout_s = 1'b0;
    case (mode_q)
      MODE_ADD, MODE_SUB: begin
        slice_res_s  = sum_s[SLICE_W-1:0];
        slice_cout_s = sum_s[SLICE_W];
      end
      MODE_AND: begin
        slice_res_s  = a_s & b_s;
        slice_cout_s = 1'b0;
      end
      MODE_XOR: begin
        slice_res_s  = a_s ^ b_s;
        slice_cout_s = 1'b0;
      end
      default: begin
        slice_res_s  = {SLICE_W{1'b0}};
        slice_cout_s = 1'b0;
      end
    endcase
    acc_ins_s = acc_q;
    acc_ins_s[cnt_q*SLICE_W +: SLICE_W] = slice_res_s;
  end

  // Next-state and datapath-register update logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    alu_out_d   = alu_out_q;
    carry_out_d = carry_out_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op0_d   = op0_value;
          op1_d   = op1_value;
          mode_d  = mode;
          cnt_d   = {CNT_W{1'b0}};
          carry_d = (mode == MODE_SUB);
          acc_d   = {256{1'b0}};
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d   = acc_ins_s;
        carry_d = slice_cout_s;
        if (cnt_q == LAST_SLICE) begin
          // Outputs only change once the whole word is assembled.
          alu_out_d   = acc_ins_s;
          carry_out_d = slice_cout_s;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      carry_q     <= 1'b0;
      op0_q       <= {256{1'b0}};
      op1_q       <= {256{1'b0}};
      mode_q      <= 2'd0;
      acc_q       <= {256{1'b0}};
      alu_out_q   <= {256{1'b0}};
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      alu_out_q   <= alu_out_d;
      carry_out_q <= carry_out_d;
    end
  end

  // Handshake flags come from the state register, forced low while reset is asserted.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_DONE) && !rst;
  assign alu_out   = alu_out_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_alu_resp.sv
// Self-checking bench for alu_resp: directed cases plus randomized operations
// compared against a 257-bit arithmetic reference model.
module tb_alu_resp;

  localparam int SLICE_W = 64;
  localparam int NSLICE  = 256 / SLICE_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [255:0] op0_value;
  logic [255:0] op1_value;
  logic [1:0]   mode;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] alu_out;
  logic         carry_out;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_resp #(.SLICE_W(SLICE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op0_value (op0_value),
    .op1_value (op1_value),
    .mode      (mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .alu_out   (alu_out),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence itself stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, bit 256 is the carry.
  function automatic logic [256:0] model(input logic [255:0] a, input logic [255:0] b,
                                         input logic [1:0] m);
    case (m)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} + {1'b0, ~b} + 257'd1;
      2'd2:    return {1'b0, a & b};
      2'd3:    return {1'b0, a ^ b};
      default: return 257'd0;
    endcase
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    int           kind;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    kind = $urandom_range(0, 3);
    if (kind == 1) r = {256{1'b1}};
    else if (kind == 2) r = {224'd0, r[31:0]};
    else if (kind == 3) r[SLICE_W-1:0] = {SLICE_W{1'b1}};
    return r;
  endfunction

  // One full transaction: accept, check latency and result, optional backpressure.
  task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [1:0] m,
                        input int hold, input bit keep_valid);
    logic [256:0] exp;
    int           lat;
    exp = model(a, b, m);
    chk("req_ready_idle", 257'(req_ready), 257'd1);
    op0_value = a;
    op1_value = b;
    mode      = m;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    step();
    chk("req_ready_busy", 257'(req_ready), 257'd0);
    // Disturb the operand inputs after acceptance; the result must not see them.
    op0_value = rand256();
    op1_value = rand256();
    mode      = 2'($urandom_range(0, 3));
    req_valid = keep_valid;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 4 * NSLICE + 8) begin
      step();
      lat++;
    end
    chk("latency", 257'(lat), 257'(NSLICE + 1));
    chk("alu_out", {1'b0, alu_out}, {1'b0, exp[255:0]});
    chk("carry_out", 257'(carry_out), 257'(exp[256]));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_rsp_valid", 257'(rsp_valid), 257'd1);
      chk("hold_req_ready", 257'(req_ready), 257'd0);
      chk("hold_result", {carry_out, alu_out}, exp);
    end
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("ret_req_ready", 257'(req_ready), 257'd1);
    chk("ret_rsp_valid", 257'(rsp_valid), 257'd0);
    chk("idle_holds_result", {carry_out, alu_out}, exp);
  endtask

  initial begin
    logic [255:0] a;
    logic [255:0] b;
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    op0_value = 256'd0;
    op1_value = 256'd0;
    mode      = 2'd0;

    // Reset behaviour.
    step();
    chk("rst_req_ready", 257'(req_ready), 257'd0);
    chk("rst_rsp_valid", 257'(rsp_valid), 257'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 257'(req_ready), 257'd1);
    chk("post_rst_result", {carry_out, alu_out}, 257'd0);

    // Add 7 + 13.
    run_op(256'd7, 256'd13, 2'd0, 0, 1'b0);
    chk("add_const", {carry_out, alu_out}, {1'b0, 256'd20});

    // Subtract with and without borrow.
    run_op(256'd5, 256'd7, 2'd1, 0, 1'b0);
    chk("sub_borrow_const", {carry_out, alu_out}, {1'b0, ~256'd1});
    run_op(256'd7, 256'd5, 2'd1, 0, 1'b0);
    chk("sub_noborrow_const", {carry_out, alu_out}, {1'b1, 256'd2});

    // Carry ripples across every slice boundary.
    a = {256{1'b1}};
    run_op(a, 256'd1, 2'd0, 0, 1'b0);
    chk("wrap_const", {carry_out, alu_out}, {1'b1, 256'd0});

    // Backpressure in DONE with req_valid held high.
    a = rand256();
    b = rand256();
    run_op(a, b, 2'd3, 3, 1'b1);

    // Reset in BUSY slice 2 discards the operation.
    a = rand256();
    op0_value = a;
    op1_value = ~a;
    mode      = 2'd0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midop_rst_req_ready", 257'(req_ready), 257'd0);
    chk("midop_rst_rsp_valid", 257'(rsp_valid), 257'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midop_idle_ready", 257'(req_ready), 257'd1);
    chk("midop_cleared", {carry_out, alu_out}, 257'd0);
    for (int i = 0; i < NSLICE + 3; i++) begin
      step();
      chk("midop_no_rsp", 257'(rsp_valid), 257'd0);
    end
    run_op(256'hF0, 256'h3C, 2'd2, 0, 1'b0);
    chk("and_const", {carry_out, alu_out}, {1'b0, 256'h30});

    // Randomized operations with random backpressure and idle gaps.
    for (int n = 0; n < 24; n++) begin
      a = rand256();
      b = rand256();
      run_op(a, b, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
      for (int g = 0; g < $urandom_range(0, 2); g++) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_resp.md
ALU_RESP -- requirements
Module: alu_resp

Interface
REQ-001 SHALL have parameter SLICE_W, default 64: datapath slice width in bits; legal values 32, 64, 128, 256.
REQ-002 SHALL derive NSLICE = 256/SLICE_W: BUSY cycles per operation (4 at default).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port op0_value  input  256  first operand, unsigned.
REQ-008 SHALL have port op1_value  input  256  second operand, unsigned.
REQ-009 SHALL have port mode  input  2  operation: 0 add, 1 sub, 2 AND, 3 XOR.
REQ-010 SHALL have port rsp_valid  output  1  result present.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port alu_out  output  256  result.
REQ-013 SHALL have port carry_out  output  1  carry out of bit 255 (add/sub), else 0.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL drive req_ready = 1 only in IDLE; rsp_valid = 1 only in DONE.
REQ-016 SHALL accept a request in the IDLE cycle where req_valid=1, capturing op0_value, op1_value, mode, and SHALL enter BUSY on that edge.
REQ-017 SHALL ignore changes on op0_value, op1_value, mode, req_valid outside the accepting cycle.
REQ-018 SHALL process slice k (bits k*SLICE_W+SLICE_W-1 : k*SLICE_W) in BUSY cycle k, k = 0..NSLICE-1, least significant first.
REQ-019 SHALL propagate a registered carry between slices; initial carry 0 for add, 1 for sub.
REQ-020 SHALL compute sub as op0 + ~op1 + 1, modulo 2^256; carry_out = final carry (1 = no borrow).
REQ-021 SHALL compute AND/XOR bitwise per slice with carry_out = 0.
REQ-022 SHALL wrap add results modulo 2^256, reporting overflow only via carry_out.
REQ-023 SHALL enter DONE on the edge ending BUSY cycle NSLICE-1; with acceptance in cycle T, rsp_valid first high in cycle T+NSLICE+1 (T+5 at default).
REQ-024 SHALL hold alu_out, carry_out, rsp_valid stable in DONE until rsp_ready=1.
REQ-025 SHALL return to IDLE on the edge where rsp_valid=1 and rsp_ready=1; req_ready high the following cycle.
REQ-026 SHALL NOT accept a new request in BUSY or DONE (no overlap, no bypass).
REQ-027 SHALL keep alu_out and carry_out holding the last result while in IDLE.
REQ-028 SHALL present alu_out/carry_out as registered outputs; no combinational path from inputs to outputs except none.

Reset
REQ-029 SHALL, when rst=1 at a rising edge, enter IDLE and clear alu_out, carry_out, slice counter, carry register to 0.
REQ-030 SHALL drive req_ready=0 and rsp_valid=0 during any cycle in which rst=1 is sampled... and req_ready=1 in the first cycle after rst deasserts.
REQ-031 SHALL discard an in-flight operation on reset in BUSY or DONE; no response issued for it.
REQ-032 SHALL give rst priority over all handshakes in the same cycle.

Verification
REQ-033 Add: op0=7, op1=13, mode=0, accept cycle T, rsp_ready=1 -> rsp_valid in T+5, alu_out=20, carry_out=0.
REQ-034 Sub borrow: op0=5, op1=7, mode=1 -> alu_out=2^256-2, carry_out=0; op0=7, op1=5 -> alu_out=2, carry_out=1.
REQ-035 Wrap: op0=2^256-1, op1=1, mode=0 -> alu_out=0, carry_out=1; carry crosses all slice boundaries.
REQ-036 Backpressure: rsp_ready=0 for 3 cycles in DONE -> rsp_valid, alu_out stable, req_ready=0; req_valid held high is not accepted until after response handshake.
REQ-037 Reset mid-op: rst=1 in BUSY cycle 2 -> next cycle IDLE, alu_out=0, carry_out=0, no rsp_valid; new request 0xF0 AND 0x3C, mode=2 -> alu_out=0x30.
REQ-038 Operand stability: change op0/op1/mode in cycle T+1 after acceptance -> result reflects values captured in cycle T.
